// File: rtl/reg_addr_sel_pipe.sv
// Register-address select pipe: picks one of NUM_IN candidate addresses and
// buffers {address, write-enable} in a 2-entry FIFO with a sticky bad-select flag.
module reg_addr_sel_pipe #(
  parameter int WIDTH         = 5,
  parameter int NUM_IN        = 4,
  parameter int SEL_W         = 2,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_we,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_we,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic             we0_q, we0_d, we1_q, we1_d;
  logic             sel_err_q, sel_err_d;

  logic             push_s, pop_s, sel_oob_s, new_we_s;
  logic [WIDTH-1:0] new_addr_s;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign out_data  = out_valid ? addr0_q : {WIDTH{1'b0}};
  assign out_we    = out_valid ? we0_q : 1'b0;
  assign sel_err   = sel_err_q;

  // Build the candidate entry from the selected channel.
  always_comb begin
    new_addr_s = {WIDTH{1'b0}};
    new_we_s   = 1'b0;
    sel_oob_s  = ({1'b0, in_sel} >= NUM_IN_L);
    for (int k = 0; k < NUM_IN; k++) begin
      new_addr_s = ({1'b0, in_sel} == (SEL_W+1)'(k)) ? in_data[k*WIDTH +: WIDTH] : new_addr_s;
    end
    if (sel_oob_s) begin
      new_we_s = 1'b0;
    end else if ((ZERO_SUPPRESS != 0) && (new_addr_s == {WIDTH{1'b0}})) begin
      new_we_s = 1'b0;
    end else begin
      new_we_s = in_we;
    end
  end

  // FIFO next-state; flush overrides any same-cycle push or pop.
  always_comb begin
    state_d   = state_q;
    addr0_d   = addr0_q;
    we0_d     = we0_q;
    addr1_d   = addr1_q;
    we1_d     = we1_q;
    sel_err_d = sel_err_q | (push_s & sel_oob_s & ~flush);
    if (flush) begin
      state_d = EMPTY;
      addr0_d = {WIDTH{1'b0}};
      we0_d   = 1'b0;
      addr1_d = {WIDTH{1'b0}};
      we1_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d = ONE;
            addr0_d = new_addr_s;
            we0_d   = new_we_s;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            addr0_d = new_addr_s;
            we0_d   = new_we_s;
          end else if (push_s) begin
            state_d = FULL;
            addr1_d = new_addr_s;
            we1_d   = new_we_s;
          end else if (pop_s) begin
            state_d = EMPTY;
            addr0_d = {WIDTH{1'b0}};
            we0_d   = 1'b0;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (pop_s) begin
            state_d = ONE;
            addr0_d = addr1_q;
            we0_d   = we1_q;
            addr1_d = {WIDTH{1'b0}};
            we1_d   = 1'b0;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
          addr0_d = {WIDTH{1'b0}};
          we0_d   = 1'b0;
          addr1_d = {WIDTH{1'b0}};
          we1_d   = 1'b0;
        end
      endcase
    end
  end

  // State and entry registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      addr0_q   <= {WIDTH{1'b0}};
      we0_q     <= 1'b0;
      addr1_q   <= {WIDTH{1'b0}};
      we1_q     <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr0_q   <= addr0_d;
      we0_q     <= we0_d;
      addr1_q   <= addr1_d;
      we1_q     <= we1_d;
      sel_err_q <= sel_err_d;
    end
  end

endmodule

// File: doc/reg_addr_sel_pipe.md
REG_ADDR_SEL_PIPE -- requirements
Module: reg_addr_sel_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5, register-address width in bits.
REQ-002 SHALL have parameter NUM_IN, default 4, number of candidate address channels (2..16).
REQ-003 SHALL have parameter SEL_W, default 2, select width; SEL_W >= ceil(log2(NUM_IN)).
REQ-004 SHALL have parameter ZERO_SUPPRESS, default 1, which forces write-enable low when the selected address is 0.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset; state clears immediately on 0 and releases on 1.
REQ-007 SHALL have port in_data  input  NUM_IN*WIDTH  candidate addresses; channel k at bits [k*WIDTH +: WIDTH].
REQ-008 SHALL have port in_sel  input  SEL_W  channel select.
REQ-009 SHALL have port in_we  input  1  requested write-enable accompanying the address.
REQ-010 SHALL have port in_valid  input  1  upstream holds a valid request.
REQ-011 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-012 SHALL have port flush  input  1  synchronous discard of all buffered and incoming entries.
REQ-013 SHALL have port out_data  output  WIDTH  selected address at the buffer head.
REQ-014 SHALL have port out_we  output  1  write-enable at the buffer head.
REQ-015 SHALL have port out_valid  output  1  buffer head is valid.
REQ-016 SHALL have port out_ready  input  1  downstream accepts the head this cycle.
REQ-017 SHALL have port sel_err  output  1  sticky flag set by an out-of-range select.

Function
REQ-018 SHALL accept a request on a rising edge when in_valid=1 and in_ready=1, and SHALL pop the head when out_valid=1 and out_ready=1.
REQ-019 SHALL compute the stored address as in_data channel in_sel, and the stored we as in_we.
REQ-020 SHALL, when in_sel >= NUM_IN on an accepted request, store address 0 and we 0, and set sel_err to 1 on that edge.
REQ-021 SHALL, when ZERO_SUPPRESS=1 and the stored address is 0, store we 0 regardless of in_we.
REQ-022 SHALL buffer entries in a 2-entry FIFO with states EMPTY, ONE and FULL, where occupancy equals the state.
REQ-023 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded directly from registered state.
REQ-024 SHALL drive out_data and out_we from the head entry when out_valid=1, and SHALL drive them to 0 when out_valid=0.
REQ-025 SHALL give one-cycle latency: a request accepted in EMPTY appears on out_* with out_valid=1 in the following cycle.
REQ-026 SHALL apply these transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with the new entry becoming head; FULL+pop->ONE with the second entry becoming head; otherwise the state holds.
REQ-027 SHALL preserve FIFO order with no entry lost or duplicated.
REQ-028 SHALL, when flush=1 on an edge, go to EMPTY and discard all entries, including any same-cycle push, since flush has priority over push and pop.
REQ-029 SHALL leave sel_err unchanged on flush; sel_err SHALL be cleared only by reset.
REQ-030 SHALL ignore in_sel, in_data and in_we when no push occurs, and SHALL NOT set sel_err on a non-accepted out-of-range select.

Reset
REQ-031 SHALL, while reset=0, force state EMPTY, clear both entries, and drive in_ready=1, out_valid=0, out_data=0, out_we=0 and sel_err=0.
REQ-032 SHALL, on reset assertion mid-operation, drop buffered entries immediately without waiting for a clock edge.

Verification
REQ-033 SHALL be verified by: reset, then push sel=2 with in_data ch2=5'd31 and we=1 -> next cycle out_valid=1, out_data=31, out_we=1.
REQ-034 SHALL be verified by: out_ready=0, push ch1=7 then ch3=9 -> in_ready=0 (FULL); then out_ready=1 -> pops 7 then 9 in order.
REQ-035 SHALL be verified by: push a selected address of 0 with we=1 and ZERO_SUPPRESS=1 -> out_data=0 and out_we=0.
REQ-036 SHALL be verified by: NUM_IN=3, SEL_W=2, push sel=3 -> out_data=0, out_we=0, sel_err=1; sel_err stays 1 after a subsequent flush.
REQ-037 SHALL be verified by: in state ONE, push, pop and flush in the same cycle -> next cycle out_valid=0 and in_ready=1.
REQ-038 SHALL be verified by: in state FULL, reset=0 asserted between clock edges -> out_valid=0 immediately, and all outputs at REQ-031 values.
